// File: rtl/mem_bus_arbiter_if.sv
// Native valid/ready memory bus: one requester-to-responder link.
// The master modport is the side that issues requests, the slave modport answers them.
interface mem_bus_arbiter_if;
   logic        valid;
   logic        instr;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        ready;
   logic [31:0] rdata;

   modport master (
      output valid, instr, addr, wdata, wstrb,
      input  ready, rdata
   );

   modport slave (
      input  valid, instr, addr, wdata, wstrb,
      output ready, rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master, one-slave round-robin arbiter for the native memory bus.
// One transaction in flight; the grant is held until the slave completes,
// the granted master withdraws its request, or (optionally) a timeout expires.
// Optional feature: define MEM_BUS_ARB_TIMEOUT_EN to add the busy-cycle
// timeout that force-completes a stuck transfer with ERR_RDATA.
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic                clk,
   input  logic                reset,
   mem_bus_arbiter_if.slave    m0,
   mem_bus_arbiter_if.slave    m1,
   mem_bus_arbiter_if.master   s,
   output logic [1:0]          grant,
   output logic                timeout_err
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0] state_reg, state_next;
   logic [1:0] grant_reg, grant_next;
   logic       last_reg, last_next;

   logic        busy;
   logic        sel;
   logic        req_valid;
   logic        req_instr;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_wstrb;
   logic        complete;
   logic        expire;
   logic        finish;
   logic        abort;
   logic [31:0] resp_rdata;

   // Owner is decoded from the registered grant; request fields are a live mux.
   assign busy      = (state_reg == BUSY);
   assign sel       = grant_reg[1];
   assign req_valid = sel ? m1.valid : m0.valid;
   assign req_instr = sel ? m1.instr : m0.instr;
   assign req_addr  = sel ? m1.addr  : m0.addr;
   assign req_wdata = sel ? m1.wdata : m0.wdata;
   assign req_wstrb = sel ? m1.wstrb : m0.wstrb;

   assign complete  = busy & s.ready;

`ifdef MEM_BUS_ARB_TIMEOUT_EN
   logic [CNT_W-1:0] cnt_reg;
   logic             timeout_err_reg;

   // Expiry loses to a slave completion arriving on the same cycle.
   assign expire = busy & ~s.ready & (cnt_reg == CNT_W'(TIMEOUT_CYCLES));

   // Busy-cycle counter: held at zero while idle, counts stalled busy cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_reg <= '0;
      else if (!busy)
         cnt_reg <= '0;
      else if (!s.ready)
         cnt_reg <= cnt_reg + 1'b1;
   end

   // Sticky timeout flag, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         timeout_err_reg <= 1'b0;
      else if (expire)
         timeout_err_reg <= 1'b1;
   end

   assign timeout_err = timeout_err_reg;
`else
   assign expire      = 1'b0;
   assign timeout_err = 1'b0;
`endif

   assign finish     = complete | expire;
   // Withdrawn request without completion drops the transfer; last owner kept.
   assign abort      = busy & ~finish & ~req_valid;
   assign resp_rdata = expire ? ERR_RDATA : s.rdata;

   // Slave side: driven only while a transfer is in flight, zero otherwise.
   assign s.valid = busy;
   assign s.instr = busy & req_instr;
   assign s.addr  = busy ? req_addr  : 32'd0;
   assign s.wdata = busy ? req_wdata : 32'd0;
   assign s.wstrb = busy ? req_wstrb : 4'd0;

   // Master side: only the current owner sees ready/rdata, for one cycle.
   assign m0.ready = finish & grant_reg[0];
   assign m1.ready = finish & grant_reg[1];
   assign m0.rdata = (finish & grant_reg[0]) ? resp_rdata : 32'd0;
   assign m1.rdata = (finish & grant_reg[1]) ? resp_rdata : 32'd0;

   assign grant = grant_reg;

   // Arbitration and transfer sequencing.
   always_comb begin
      state_next = state_reg;
      grant_next = grant_reg;
      last_next  = last_reg;
      case (state_reg)
         IDLE: begin
            if (m0.valid && m1.valid) begin
               // Tie goes to whichever master was not served last.
               grant_next = last_reg ? 2'b01 : 2'b10;
               state_next = BUSY;
            end else if (m0.valid) begin
               grant_next = 2'b01;
               state_next = BUSY;
            end else if (m1.valid) begin
               grant_next = 2'b10;
               state_next = BUSY;
            end
         end
         BUSY: begin
            if (finish) begin
               state_next = IDLE;
               grant_next = 2'b00;
               last_next  = sel;
            end else if (abort) begin
               state_next = IDLE;
               grant_next = 2'b00;
            end
         end
         default: begin
            state_next = IDLE;
            grant_next = 2'b00;
         end
      endcase
   end

   // State, owner and round-robin history registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         grant_reg <= 2'b00;
         last_reg  <= 1'b1;
      end else begin
         state_reg <= state_next;
         grant_reg <= grant_next;
         last_reg  <= last_next;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: table-driven transactions with a
// scoreboard queue of expected slave-side requests and master responses,
// plus hand-written sequences for contention, abort, timeout and reset.
module tb_mem_bus_arbiter;

   typedef struct {
      logic [1:0]  req;
      logic        first;
      logic        instr0;
      logic [31:0] addr0;
      logic [31:0] wdata0;
      logic [3:0]  wstrb0;
      logic        instr1;
      logic [31:0] addr1;
      logic [31:0] wdata1;
      logic [3:0]  wstrb1;
      int          lat;
      logic [31:0] rdata;
   } vec_t;

   typedef struct {
      logic        m;
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int          lat;
      logic [31:0] rdata;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] grant;
   logic       timeout_err;

   int checks = 0;
   int errors = 0;

   exp_t sb[$];
   vec_t vecs[6];

   mem_bus_arbiter_if m0_bus();
   mem_bus_arbiter_if m1_bus();
   mem_bus_arbiter_if s_bus();

   mem_bus_arbiter dut (
      .clk         (clk),
      .reset       (reset),
      .m0          (m0_bus),
      .m1          (m1_bus),
      .s           (s_bus),
      .grant       (grant),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_req(input logic m, input logic instr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] wstrb);
      if (!m) begin
         m0_bus.valid = 1'b1; m0_bus.instr = instr; m0_bus.addr = addr;
         m0_bus.wdata = wdata; m0_bus.wstrb = wstrb;
      end else begin
         m1_bus.valid = 1'b1; m1_bus.instr = instr; m1_bus.addr = addr;
         m1_bus.wdata = wdata; m1_bus.wstrb = wstrb;
      end
   endtask

   task automatic drop(input logic m);
      if (!m) begin
         m0_bus.valid = 1'b0; m0_bus.instr = 1'b0; m0_bus.addr = '0;
         m0_bus.wdata = '0; m0_bus.wstrb = '0;
      end else begin
         m1_bus.valid = 1'b0; m1_bus.instr = 1'b0; m1_bus.addr = '0;
         m1_bus.wdata = '0; m1_bus.wstrb = '0;
      end
   endtask

   // Drive a request and record what the slave and master must later see.
   task automatic request(input logic m, input logic instr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wstrb,
                          input int lat, input logic [31:0] rdata);
      exp_t e;
      drive_req(m, instr, addr, wdata, wstrb);
      e.m = m; e.instr = instr; e.addr = addr; e.wdata = wdata;
      e.wstrb = wstrb; e.lat = lat; e.rdata = rdata;
      sb.push_back(e);
   endtask

   // Acts as the slave for the next expected transfer and checks both masters.
   task automatic serve();
      exp_t       e;
      int         waited;
      logic [1:0] g;
      logic       rdy_own, rdy_oth;
      logic [31:0] rd_own, rd_oth;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL serve_empty: got 0 queued expected 1");
         return;
      end
      e = sb.pop_front();
      g = e.m ? 2'b10 : 2'b01;
      waited = 0;
      @(negedge clk);
      while (!s_bus.valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!s_bus.valid) begin
         checks++; errors++;
         $display("FAIL serve_wait: got s_valid 0 expected 1 within 20 cycles");
         return;
      end
      chk("grant_busy", {30'd0, grant}, {30'd0, g});
      chk("s_addr", s_bus.addr, e.addr);
      chk("s_wdata", s_bus.wdata, e.wdata);
      chk("s_wstrb", {28'd0, s_bus.wstrb}, {28'd0, e.wstrb});
      chk("s_instr", {31'd0, s_bus.instr}, {31'd0, e.instr});
      for (int k = 0; k < e.lat; k++) begin
         chk("early_ready", {30'd0, m1_bus.ready, m0_bus.ready}, 32'd0);
         chk("grant_hold", {30'd0, grant}, {30'd0, g});
         @(negedge clk);
      end
      s_bus.ready = 1'b1;
      s_bus.rdata = e.rdata;
      #1;
      rdy_own = e.m ? m1_bus.ready : m0_bus.ready;
      rdy_oth = e.m ? m0_bus.ready : m1_bus.ready;
      rd_own  = e.m ? m1_bus.rdata : m0_bus.rdata;
      rd_oth  = e.m ? m0_bus.rdata : m1_bus.rdata;
      chk("own_ready", {31'd0, rdy_own}, 32'd1);
      chk("own_rdata", rd_own, e.rdata);
      chk("other_ready", {31'd0, rdy_oth}, 32'd0);
      chk("other_rdata", rd_oth, 32'd0);
      @(posedge clk);
      #1;
      s_bus.ready = 1'b0;
      s_bus.rdata = '0;
      drop(e.m);
      @(negedge clk);
      chk("idle_grant", {30'd0, grant}, 32'd0);
      chk("idle_s_valid", {31'd0, s_bus.valid}, 32'd0);
      $display("txn m%0d instr=%0b addr=%h wdata=%h wstrb=%b lat=%0d rdata=%h",
               e.m, e.instr, e.addr, e.wdata, e.wstrb, e.lat, e.rdata);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int   waited;
      int   n;
      logic seen;
      vec_t v;

      vecs[0] = '{2'b01, 1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'b0000,
                  1'b0, 32'h0, 32'h0, 4'b0000, 3, 32'h1234_5678};
      vecs[1] = '{2'b11, 1'b1, 1'b0, 32'h0000_0104, 32'h0, 4'b0000,
                  1'b0, 32'h0000_1000, 32'h0, 4'b0000, 1, 32'hAAAA_0001};
      vecs[2] = '{2'b11, 1'b1, 1'b0, 32'h0000_0108, 32'h1111_2222, 4'b1111,
                  1'b1, 32'h0000_1004, 32'h0, 4'b0000, 0, 32'h5555_0002};
      vecs[3] = '{2'b10, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000,
                  1'b0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0011, 2, 32'h0000_0003};
      vecs[4] = '{2'b11, 1'b0, 1'b1, 32'h0000_0000, 32'h0, 4'b0000,
                  1'b0, 32'h0000_2004, 32'hCAFE_F00D, 4'b1100, 1, 32'h7777_0004};
      vecs[5] = '{2'b01, 1'b0, 1'b0, 32'h0000_010C, 32'h0000_00EE, 4'b0001,
                  1'b0, 32'h0, 32'h0, 4'b0000, 0, 32'h0000_0005};

      drop(1'b0);
      drop(1'b1);
      s_bus.ready = 1'b0;
      s_bus.rdata = '0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      chk("rst_grant", {30'd0, grant}, 32'd0);
      chk("rst_s_valid", {31'd0, s_bus.valid}, 32'd0);
      chk("rst_s_addr", s_bus.addr, 32'd0);
      chk("rst_ready", {30'd0, m1_bus.ready, m0_bus.ready}, 32'd0);
      chk("rst_timeout_err", {31'd0, timeout_err}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Table-driven transfers; both-request rows check the round-robin order.
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         @(posedge clk);
         #1;
         n = 0;
         for (int j = 0; j < 2; j++) begin
            logic m;
            m = (j == 0) ? v.first : ~v.first;
            if (v.req[m]) begin
               if (!m)
                  request(1'b0, v.instr0, v.addr0, v.wdata0, v.wstrb0, v.lat, v.rdata);
               else
                  request(1'b1, v.instr1, v.addr1, v.wdata1, v.wstrb1, v.lat, v.rdata ^ 32'hFFFF_0000);
               n++;
            end
         end
         for (int j = 0; j < n; j++)
            serve();
      end

      // m1 write arrives while m0 is busy: waits, then is served unchanged.
      @(posedge clk);
      #1 request(1'b0, 1'b0, 32'h0000_0300, 32'h0, 4'b0000, 2, 32'h0300_0300);
      @(posedge clk);
      #1 request(1'b1, 1'b0, 32'h0000_2000, 32'hA5A5_A5A5, 4'b0011, 2, 32'h0000_0033);
      serve();
      serve();

      // s_ready while idle must not produce any master ready or start a transfer.
      @(posedge clk);
      #1 s_bus.ready = 1'b1;
      s_bus.rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      chk("idle_sready_ready", {30'd0, m1_bus.ready, m0_bus.ready}, 32'd0);
      chk("idle_sready_rdata", m0_bus.rdata | m1_bus.rdata, 32'd0);
      @(posedge clk);
      #1 s_bus.ready = 1'b0;
      s_bus.rdata = '0;
      @(negedge clk);
      chk("idle_sready_grant", {30'd0, grant}, 32'd0);

      // m0 withdraws mid-transfer: no ready, back to idle, history unchanged.
      @(posedge clk);
      #1 drive_req(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'b0000);
      waited = 0;
      @(negedge clk);
      while (!s_bus.valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("abort_grant", {30'd0, grant}, 32'd1);
      @(posedge clk);
      #1 drop(1'b0);
      @(negedge clk);
      chk("abort_no_ready", {31'd0, m0_bus.ready}, 32'd0);
      @(negedge clk);
      chk("abort_idle_grant", {30'd0, grant}, 32'd0);
      chk("abort_idle_valid", {31'd0, s_bus.valid}, 32'd0);
      // m1 was served last before the abort, so m0 still wins the next tie.
      @(posedge clk);
      #1 request(1'b0, 1'b0, 32'h0000_0404, 32'h0, 4'b0000, 1, 32'h0404_0404);
      request(1'b1, 1'b0, 32'h0000_1404, 32'h0, 4'b0000, 1, 32'h1404_1404);
      serve();
      serve();

      // Slave never answers.
      @(posedge clk);
      #1 drive_req(1'b0, 1'b0, 32'h0000_0500, 32'h0, 4'b0000);
      waited = 0;
      @(negedge clk);
      while (!s_bus.valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
      n = 0;
      while (!m0_bus.ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycle", n, 32'd255);
      chk("timeout_rdata", m0_bus.rdata, 32'hDEAD_BEEF);
      chk("timeout_s_valid", {31'd0, s_bus.valid}, 32'd1);
      @(posedge clk);
      #1 drop(1'b0);
      @(negedge clk);
      chk("timeout_err_set", {31'd0, timeout_err}, 32'd1);
      chk("timeout_idle_grant", {30'd0, grant}, 32'd0);
      @(posedge clk);
      #1 request(1'b1, 1'b0, 32'h0000_1500, 32'h0, 4'b0000, 1, 32'h1500_1500);
      serve();
      chk("timeout_err_sticky", {31'd0, timeout_err}, 32'd1);
`else
      seen = 1'b0;
      for (int k = 0; k < 300; k++) begin
         if (m0_bus.ready || !s_bus.valid)
            seen = 1'b1;
         @(negedge clk);
      end
      chk("no_timeout_stall", {31'd0, seen}, 32'd0);
      chk("no_timeout_err", {31'd0, timeout_err}, 32'd0);
      exp_t_push_release: begin
         exp_t e;
         e.m = 1'b0; e.instr = 1'b0; e.addr = 32'h0000_0500; e.wdata = '0;
         e.wstrb = '0; e.lat = 0; e.rdata = 32'h0500_0500;
         sb.push_back(e);
      end
      serve();
`endif

      // Asynchronous reset in the middle of a transfer.
      @(posedge clk);
      #1 drive_req(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'b0000);
      waited = 0;
      @(negedge clk);
      while (!s_bus.valid && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      chk("pre_reset_valid", {31'd0, s_bus.valid}, 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("midrst_s_valid", {31'd0, s_bus.valid}, 32'd0);
      chk("midrst_grant", {30'd0, grant}, 32'd0);
      chk("midrst_ready", {30'd0, m1_bus.ready, m0_bus.ready}, 32'd0);
      chk("midrst_timeout_err", {31'd0, timeout_err}, 32'd0);
      drive_req(1'b1, 1'b0, 32'h0000_1600, 32'h0, 4'b0000);
      @(posedge clk);
      #1 reset = 1'b0;
      sb.delete();
      begin
         exp_t e;
         e.m = 1'b0; e.instr = 1'b0; e.addr = 32'h0000_0600; e.wdata = '0;
         e.wstrb = '0; e.lat = 1; e.rdata = 32'h0600_0600;
         sb.push_back(e);
         e.m = 1'b1; e.addr = 32'h0000_1600; e.rdata = 32'h1600_1600;
         sb.push_back(e);
      end
      serve();
      serve();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
